// File: rtl/axil_spi_flash_rd_slave.sv
// AXI4-Lite read-only slave: each AR request becomes one SPI-flash READ (0x03),
// returning the flash bytes little-endian on R.
module axil_spi_flash_rd_slave #(
    parameter int          ADDR_W   = 24,
    parameter int          DATA_W   = 32,
    parameter int          CLK_DIV  = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [7:0]  CMD_READ = 8'h03
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int N_BITS  = 8 + ADDR_W + DATA_W;
    localparam int TX_W    = 8 + ADDR_W;
    localparam int BIT_W   = $clog2(N_BITS + 1);
    localparam int DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [TX_W-1:0]    r_tx;
    logic [DATA_W-1:0]  r_rx;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  w_swap;
    logic               r_arready;
    logic               r_rvalid;
    logic               r_sclk;
    logic               r_cs_n;
    logic               r_mosi;
    logic               w_div_done;
    logic               w_last;
    logic               w_gap_ok;
    logic               w_ar_hs;
    logic               w_r_hs;

    assign w_div_done = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last     = (r_bit == BIT_W'(N_BITS - 1));
    assign w_gap_ok   = (r_div >= DIV_W'(CS_GAP - 1));
    assign w_ar_hs    = arvalid && r_arready;
    assign w_r_hs     = r_rvalid && rready;

    // Flash streams bytes MSB-first; byte k received lands in rdata[8k+7:8k]
    always_comb begin
        w_swap = '0;
        for (int k = 0; k < DATA_W / 8; k++) begin
            w_swap[8*k +: 8] = r_rx[DATA_W-1-8*k -: 8];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_ar_hs) w_next = SETUP;
            SETUP: if (w_div_done) w_next = SHIFT;
            SHIFT: if (w_div_done && !r_sclk && w_last) w_next = HOLD;
            HOLD:  if (w_div_done) w_next = RESP;
            RESP:  if (w_gap_ok && (!r_rvalid || rready)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
        end else begin
            r_arready <= (w_next == IDLE);
            unique case (r_state)
                IDLE: begin
                    r_div <= '0;
                    if (w_ar_hs) begin
                        r_cs_n <= 1'b0;
                        r_mosi <= CMD_READ[7];
                        r_tx   <= {CMD_READ[6:0], araddr, 1'b0};
                        r_bit  <= '0;
                    end
                end
                SETUP: begin
                    if (w_div_done) begin
                        r_div  <= '0;
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[DATA_W-2:0], spi_miso};
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            r_mosi <= r_tx[TX_W-1];
                            r_tx   <= r_tx << 1;
                        end else if (!w_last) begin
                            r_sclk <= 1'b1;
                            r_bit  <= r_bit + 1'b1;
                            r_rx   <= {r_rx[DATA_W-2:0], spi_miso};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_div_done) begin
                        r_div    <= '0;
                        r_cs_n   <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_swap;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                RESP: begin
                    if (w_r_hs) r_rvalid <= 1'b0;
                    // r_div now counts cycles spent with cs_n high
                    if (!w_gap_ok) r_div <= r_div + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign arready  = r_arready;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = 2'b00;
    assign spi_sclk = r_sclk;
    assign spi_cs_n = r_cs_n;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_axil_spi_flash_rd_slave.sv
// Directed bench for axil_spi_flash_rd_slave with a behavioural SPI flash
// that serves bytes from model_bytes and records the MOSI stream.
module tb_axil_spi_flash_rd_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [23:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    axil_spi_flash_rd_slave dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Flash model: {byte0,byte1,byte2,byte3} served MSB-first after 32 rises
    logic [31:0] model_bytes = '0;
    logic [63:0] mosi_cap = '0;
    int rise_cnt = 0;
    int sclk_bad = 0;
    int hi_run = 0;
    int last_gap = 0;

    always @(negedge spi_cs_n) rise_cnt = 0;

    always @(posedge spi_sclk) begin
        if (spi_cs_n !== 1'b0) sclk_bad++;
        mosi_cap = {mosi_cap[62:0], spi_mosi};
        rise_cnt++;
    end

    always @(negedge spi_sclk) begin
        if (rise_cnt >= 32 && rise_cnt < 64) spi_miso = model_bytes[63-rise_cnt];
        else spi_miso = 1'b0;
    end

    always @(negedge ACLK) begin
        if (spi_cs_n === 1'b1) hi_run++;
        else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic start_ar(input logic [23:0] a, input bit hold,
                            output int h, output bit ok);
        ok = 1'b0;
        h = 0;
        araddr = a;
        arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (arready === 1'b1) begin
                @(posedge ACLK);
                @(negedge ACLK);
                h = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        if (!hold) arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int r, output bit ok);
        ok = 1'b0;
        r = 0;
        for (int i = 0; i < 400; i++) begin
            if (rvalid === 1'b1) begin
                r = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic r_pulse();
        rready = 1'b1;
        @(negedge ACLK);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        vectors++;
        if ({arready, rvalid, rdata, rresp, spi_sclk, spi_cs_n, spi_mosi}
            !== {1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got ar=%b rv=%b rd=%h rr=%b sclk=%b cs=%b mosi=%b want 0 0 0 0 0 1 0",
                     arready, rvalid, rdata, rresp, spi_sclk, spi_cs_n, spi_mosi);
        end
        ARESETn = 1'b1;
        @(negedge ACLK);
        vectors++;
        if (arready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_arready_release: got %b want 1", arready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int h;
        bit ok;
        int bad;
        model_bytes = 32'h55AA55AA;
        start_ar(24'h123456, 1'b0, h, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_ar_timeout: got %b want 1", ok);
        end
        repeat (40) @(negedge ACLK);
        ARESETn = 1'b0;
        @(negedge ACLK);
        vectors++;
        if ({spi_cs_n, spi_sclk, rvalid, arready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL t1_reset_mid_shift: got cs=%b sclk=%b rv=%b ar=%b want 1 0 0 0",
                     spi_cs_n, spi_sclk, rvalid, arready);
        end
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        vectors++;
        if (arready !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_arready_after: got %b want 1", arready);
        end
        bad = 0;
        repeat (300) begin
            if (rvalid !== 1'b0 || spi_cs_n !== 1'b1) bad++;
            @(negedge ACLK);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL t1_no_r_beat: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_read();
        int h;
        int r;
        bit ok1;
        bit ok2;
        model_bytes = 32'h11223344;
        start_ar(24'h0AB0B9, 1'b0, h, ok1);
        wait_rvalid(r, ok2);
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++;
            $display("FAIL t2_timeout: got %b want 11", {ok1, ok2});
        end
        vectors++;
        if (r - h !== 260) begin
            miscompares++;
            $display("FAIL t2_latency: got %0d want 260", r - h);
        end
        vectors++;
        if (rdata !== 32'h44332211) begin
            miscompares++;
            $display("FAIL t2_rdata: got %h want 44332211", rdata);
        end
        vectors++;
        if (rresp !== 2'b00) begin
            miscompares++;
            $display("FAIL t2_rresp: got %b want 00", rresp);
        end
        vectors++;
        if (mosi_cap !== 64'h030AB0B9_00000000) begin
            miscompares++;
            $display("FAIL t2_mosi: got %h want 030ab0b900000000", mosi_cap);
        end
        vectors++;
        if (rise_cnt !== 64) begin
            miscompares++;
            $display("FAIL t2_sclk_rises: got %0d want 64", rise_cnt);
        end
        r_pulse();
        vectors++;
        if ({rvalid, rdata} !== {1'b0, 32'h44332211}) begin
            miscompares++;
            $display("FAIL t2_after_rhs: got rv=%b rd=%h want 0 44332211", rvalid, rdata);
        end
    endtask

    task automatic test_rready_stall();
        int h;
        int r;
        bit ok1;
        bit ok2;
        int bad;
        model_bytes = 32'hDEADBEEF;
        start_ar(24'h000040, 1'b0, h, ok1);
        wait_rvalid(r, ok2);
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++;
            $display("FAIL t3_timeout: got %b want 11", {ok1, ok2});
        end
        bad = 0;
        repeat (50) begin
            if ({rvalid, rdata, arready, spi_cs_n} !== {1'b1, 32'hEFBEADDE, 1'b0, 1'b1}) bad++;
            @(negedge ACLK);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL t3_stall_hold: got %0d bad cycles want 0 (rd=%h)", bad, rdata);
        end
        r_pulse();
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_rvalid_drop: got %b want 0", rvalid);
        end
    endtask

    task automatic test_arvalid_held();
        int h;
        bit ok1;
        bit ok2;
        int extra;
        int cs_low;
        model_bytes = 32'h0F1E2D3C;
        start_ar(24'h00ABCD, 1'b1, h, ok1);
        extra = 0;
        cs_low = 0;
        ok2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rvalid === 1'b1) begin
                ok2 = 1'b1;
                break;
            end
            if (arvalid && arready === 1'b1) extra++;
            if (spi_cs_n === 1'b0) cs_low++;
            @(negedge ACLK);
        end
        arvalid = 1'b0;
        vectors++;
        if ({ok1, ok2} !== 2'b11) begin
            miscompares++;
            $display("FAIL t4_timeout: got %b want 11", {ok1, ok2});
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL t4_extra_accept: got %0d want 0", extra);
        end
        vectors++;
        if (cs_low !== 260) begin
            miscompares++;
            $display("FAIL t4_cs_low: got %0d want 260", cs_low);
        end
        vectors++;
        if (rise_cnt !== 64) begin
            miscompares++;
            $display("FAIL t4_sclk_rises: got %0d want 64", rise_cnt);
        end
        vectors++;
        if (rdata !== 32'h3C2D1E0F) begin
            miscompares++;
            $display("FAIL t4_rdata: got %h want 3c2d1e0f", rdata);
        end
        r_pulse();
    endtask

    task automatic test_addr_extremes();
        logic [23:0] addrs [2];
        logic [31:0] bytes [2];
        logic [31:0] exp_rd [2];
        logic [31:0] exp_cmd [2];
        int h;
        int r;
        bit ok1;
        bit ok2;
        addrs   = '{24'hFFFFFF, 24'h000000};
        bytes   = '{32'hA1B2C3D4, 32'h00FF8001};
        exp_rd  = '{32'hD4C3B2A1, 32'h0180FF00};
        exp_cmd = '{32'h03FFFFFF, 32'h03000000};
        for (int i = 0; i < 2; i++) begin
            model_bytes = bytes[i];
            start_ar(addrs[i], 1'b0, h, ok1);
            wait_rvalid(r, ok2);
            vectors++;
            if ({ok1, ok2} !== 2'b11) begin
                miscompares++;
                $display("FAIL t5_timeout[%0d]: got %b want 11", i, {ok1, ok2});
            end
            vectors++;
            if (mosi_cap[63:32] !== exp_cmd[i]) begin
                miscompares++;
                $display("FAIL t5_mosi[%0d]: got %h want %h", i, mosi_cap[63:32], exp_cmd[i]);
            end
            vectors++;
            if (rdata !== exp_rd[i]) begin
                miscompares++;
                $display("FAIL t5_rdata[%0d]: got %h want %h", i, rdata, exp_rd[i]);
            end
            r_pulse();
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] addrs [3];
        logic [31:0] bytes [3];
        logic [31:0] exp_rd [3];
        int h;
        int r;
        bit ok1;
        bit ok2;
        addrs  = '{24'h000100, 24'h000104, 24'h800000};
        bytes  = '{32'h01020304, 32'hCAFEF00D, 32'h80000001};
        exp_rd = '{32'h04030201, 32'h0DF0FECA, 32'h01000080};
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_bytes = bytes[i];
            start_ar(addrs[i], 1'b0, h, ok1);
            wait_rvalid(r, ok2);
            vectors++;
            if ({ok1, ok2} !== 2'b11) begin
                miscompares++;
                $display("FAIL t6_timeout[%0d]: got %b want 11", i, {ok1, ok2});
            end
            vectors++;
            if (rdata !== exp_rd[i]) begin
                miscompares++;
                $display("FAIL t6_rdata[%0d]: got %h want %h", i, rdata, exp_rd[i]);
            end
            vectors++;
            if (mosi_cap[63:32] !== {8'h03, addrs[i]}) begin
                miscompares++;
                $display("FAIL t6_mosi[%0d]: got %h want %h", i, mosi_cap[63:32], {8'h03, addrs[i]});
            end
            if (i > 0) begin
                vectors++;
                if (last_gap < 4) begin
                    miscompares++;
                    $display("FAIL t6_cs_gap[%0d]: got %0d want >=4", i, last_gap);
                end
            end
        end
        @(negedge ACLK);
        rready = 1'b0;
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_rvalid_end: got %b want 0", rvalid);
        end
    endtask

    initial begin
        @(negedge ACLK);
        test_reset();
        test_reset_mid_shift();
        test_read();
        test_rready_stall();
        test_arvalid_held();
        test_addr_extremes();
        test_back_to_back();
        vectors++;
        if (sclk_bad !== 0) begin
            miscompares++;
            $display("FAIL sclk_while_cs_high: got %0d want 0", sclk_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
